// File: rtl/jstk_spi_reader.sv
// PmodJSTK SPI poller: one 5-byte mode-0 transaction per poll period, outputs updated atomically.
// Define JSTK_LED_EN to drive the LED request bits in the command byte.
module jstk_spi_reader #(
  parameter int unsigned CLK_DIV     = 33,
  parameter int unsigned SS_SETUP    = 1000,
  parameter int unsigned BYTE_GAP    = 700,
  parameter int unsigned POLL_PERIOD = 650000,
  parameter int unsigned CENTER      = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] led_in,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  output logic [9:0] data_x,
  output logic [9:0] data_y,
  output logic [2:0] buttons,
  output logic       data_valid,
  output logic       busy
);

  localparam int unsigned CntMax0 = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int unsigned CntMax  = (CntMax0 > CLK_DIV) ? CntMax0 : CLK_DIV;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned PollW   = $clog2(POLL_PERIOD);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic             sclk_q, sclk_d;
  logic [7:0]       tx_q, tx_d;
  logic [39:0]      rx_q, rx_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       btn_q, btn_d;
  logic [7:0]       cmd_byte;
  logic             poll_wrap;

`ifdef JSTK_LED_EN
  logic [1:0] led_q, led_d;

  always_ff @(posedge clk) begin
    if (!rst) led_q <= 2'b00;
    else      led_q <= led_d;
  end

  always_comb begin
    led_d = led_q;
    if (state_q == StIdle && poll_wrap && enable) led_d = led_in;
  end

  assign cmd_byte = {6'b100000, led_q};
`else
  logic unused_led;
  assign unused_led = ^led_in;
  assign cmd_byte   = 8'h00;
`endif

  // Upper bits of the X/Y high bytes and of the button byte carry no data.
  logic unused_rx;
  assign unused_rx = ^{rx_q[31:26], rx_q[15:10], rx_q[7:3]};

  assign poll_wrap = (poll_q == PollW'(POLL_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    poll_d  = poll_wrap ? '0 : poll_q + PollW'(1);
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sclk_d  = sclk_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;

    unique case (state_q)
      StIdle: begin
        if (poll_wrap && enable) begin
          state_d = StSetup;
          cnt_d   = '0;
          byte_d  = 3'd0;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SS_SETUP - 1)) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = 3'd0;
          sclk_d  = 1'b0;
          tx_d    = cmd_byte;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[38:0], miso};
          end else if (bit_q == 3'd7) begin
            if (byte_q == 3'd4) begin
              state_d = StDone;
              x_d     = {rx_q[25:24], rx_q[39:32]};
              y_d     = {rx_q[9:8], rx_q[23:16]};
              btn_d   = rx_q[2:0];
            end else begin
              state_d = StGap;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(BYTE_GAP - 1)) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = 3'd0;
          byte_d  = byte_q + 3'd1;
          tx_d    = 8'h00;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      poll_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      sclk_q  <= 1'b0;
      tx_q    <= 8'h00;
      rx_q    <= '0;
      x_q     <= 10'(CENTER);
      y_q     <= 10'(CENTER);
      btn_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
    end
  end

  assign busy       = (state_q == StSetup) || (state_q == StShift) || (state_q == StGap);
  assign ss         = ~busy;
  assign sclk       = sclk_q;
  assign mosi       = (state_q == StShift) && tx_q[7];
  assign data_valid = (state_q == StDone);
  assign data_x     = x_q;
  assign data_y     = y_q;
  assign buttons    = btn_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Directed bench for jstk_spi_reader with a byte-stream SPI slave model and shortened timing.
module tb_jstk_spi_reader;
  localparam int CD   = 3;
  localparam int SSU  = 20;
  localparam int BG   = 10;
  localparam int PP   = 500;
  localparam int Bud  = 2 * PP;
`ifdef JSTK_LED_EN
  localparam logic [7:0] CmdExp = 8'h82;
`else
  localparam logic [7:0] CmdExp = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] led_in = 2'b10;
  logic       miso;
  logic       sclk, mosi, ss, data_valid, busy;
  logic [9:0] data_x, data_y;
  logic [2:0] buttons;

  jstk_spi_reader #(
    .CLK_DIV(CD), .SS_SETUP(SSU), .BYTE_GAP(BG), .POLL_PERIOD(PP), .CENTER(512)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .led_in(led_in), .miso(miso),
    .sclk(sclk), .mosi(mosi), .ss(ss), .data_x(data_x), .data_y(data_y),
    .buttons(buttons), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ss_falls = 0;
  int          dv_cnt = 0;
  int          pos = 0;
  logic [39:0] resp = '0;
  logic [39:0] mosi_cap = '0;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (data_valid === 1'b1) dv_cnt++;

  // Slave: MSB presented at SS fall, advanced on each SCLK falling edge.
  always @(negedge ss) begin
    pos = 0;
    ss_falls++;
    mosi_cap = '0;
  end
  always @(negedge sclk) if (ss === 1'b0) pos++;
  always @(posedge sclk) mosi_cap = {mosi_cap[38:0], mosi};
  always_comb miso = (pos < 40) ? resp[39 - pos] : 1'b0;

  typedef struct {
    logic [39:0] r;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  b;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return ss;
      1:       return sclk;
      default: return data_valid;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input string what);
    int n = 0;
    while (get_sig(sel) !== val && n < Bud) begin
      @(negedge clk);
      n++;
    end
    if (get_sig(sel) !== val) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %b expected %b", what, get_sig(sel), val);
    end
  endtask

  initial begin
    int t0, t;
    logic [9:0] hx, hy;
    logic [2:0] hb;
    int sf0, dv0;

    vecs[0] = '{40'hF4_01_2C_03_05, 10'd500,  10'd812,  3'b101};
    vecs[1] = '{40'h00_FE_00_FC_F8, 10'd512,  10'd0,    3'b000};
    vecs[2] = '{40'hFF_03_00_00_07, 10'd1023, 10'd0,    3'b111};
    vecs[3] = '{40'h00_00_FF_03_02, 10'd0,    10'd1023, 3'b010};
    vecs[4] = '{40'h3C_02_81_01_F9, 10'd572,  10'd385,  3'b001};

    repeat (3) @(negedge clk);
    chk("rst_ss", 64'(ss), 1);
    chk("rst_sclk", 64'(sclk), 0);
    chk("rst_mosi", 64'(mosi), 0);
    chk("rst_x", 64'(data_x), 512);
    chk("rst_y", 64'(data_y), 512);
    chk("rst_btn", 64'(buttons), 0);
    chk("rst_dv", 64'(data_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    rst = 1'b1;
    enable = 1'b1;

    // Timing of one transaction and the poll spacing.
    resp = vecs[0].r;
    wait_sig(0, 1'b0, "ss_fall");
    t0 = cyc;
    chk("busy_in_txn", 64'(busy), 1);
    wait_sig(1, 1'b1, "first_rise");
    chk("first_rise_delay", 64'(cyc - t0), 64'(SSU + CD));
    t = cyc;
    for (int i = 0; i < 15; i++) begin
      wait_sig(1, (i % 2 == 0) ? 1'b0 : 1'b1, "half");
      chk("half_period", 64'(cyc - t), 64'(CD));
      t = cyc;
    end
    wait_sig(1, 1'b1, "gap_rise");
    chk("byte_gap", 64'(cyc - t), 64'(BG + CD));
    chk("ss_low_in_gap", 64'(ss), 0);
    wait_sig(2, 1'b1, "dv");
    chk("txn_length", 64'(cyc - t0), 64'(SSU + 80 * CD + 4 * BG));
    wait_sig(0, 1'b0, "ss_fall2");
    chk("poll_spacing", 64'(cyc - t0), 64'(PP));

    // Table-driven transactions.
    for (int v = 0; v < 5; v++) begin
      wait_sig(0, 1'b1, "ss_idle");
      resp = vecs[v].r;
      wait_sig(0, 1'b0, "ss_fall");
      wait_sig(2, 1'b1, "dv");
      chk("vec_x", 64'(data_x), 64'(vecs[v].x));
      chk("vec_y", 64'(data_y), 64'(vecs[v].y));
      chk("vec_btn", 64'(buttons), 64'(vecs[v].b));
      chk("vec_ss_on_dv", 64'(ss), 1);
      chk("vec_mosi_cmd", 64'(mosi_cap[39:32]), 64'(CmdExp));
      chk("vec_mosi_zero", 64'(mosi_cap[31:0]), 0);
      @(negedge clk);
      chk("vec_dv_single", 64'(data_valid), 0);
      chk("vec_x_hold", 64'(data_x), 64'(vecs[v].x));
    end

    // Enable dropped during byte 2: transaction completes, then polling stops.
    wait_sig(0, 1'b1, "ss_idle");
    resp = 40'h11_02_22_01_06;
    wait_sig(0, 1'b0, "ss_fall");
    repeat (SSU + 2 * 16 * CD + 2 * BG + 5) @(negedge clk);
    enable = 1'b0;
    wait_sig(2, 1'b1, "dv_en_drop");
    chk("endrop_x", 64'(data_x), 529);
    chk("endrop_y", 64'(data_y), 290);
    chk("endrop_btn", 64'(buttons), 6);
    @(negedge clk);
    hx = data_x;
    hy = data_y;
    hb = buttons;
    sf0 = ss_falls;
    dv0 = dv_cnt;
    repeat (3 * PP) @(negedge clk);
    chk("endrop_no_ss", 64'(ss_falls - sf0), 0);
    chk("endrop_no_dv", 64'(dv_cnt - dv0), 0);
    chk("endrop_hold_x", 64'(data_x), 529);
    chk("endrop_hold_y", 64'(data_y), 290);
    chk("endrop_hold_b", 64'({hx, hy, hb} == {data_x, data_y, buttons}), 1);

    // Reset in the middle of a transaction.
    enable = 1'b1;
    wait_sig(0, 1'b0, "ss_fall_rst");
    repeat (SSU + 40) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_ss", 64'(ss), 1);
      chk("midrst_sclk", 64'(sclk), 0);
      chk("midrst_dv", 64'(data_valid), 0);
    end
    chk("midrst_x", 64'(data_x), 512);
    chk("midrst_y", 64'(data_y), 512);
    chk("midrst_btn", 64'(buttons), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
